// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, optional parity and second stop bit,
// break detection, and a receive FIFO with a valid/ready pop interface.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RX_IN,
  input  logic [5:0]                  Prescale,
  input  logic                        PAR_EN,
  input  logic                        PAR_TYP,
  input  logic                        STOP2,
  input  logic                        Data_Ready,
  output logic [DATA_WIDTH-1:0]       P_DATA,
  output logic                        Data_Valid,
  output logic                        Parity_Error,
  output logic                        Stop_Error,
  output logic                        Break,
  output logic                        Overrun,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 3;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_WAIT_IDLE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic                  rx_prev;
  logic [5:0]            p_lat;
  logic                  par_en_lat;
  logic                  par_typ_lat;
  logic                  stop2_lat;
  logic [5:0]            cnt_q;
  logic [5:0]            half;
  logic [5:0]            half_m1;
  logic [5:0]            half_p1;
  logic [5:0]            last_cnt;
  logic [BW-1:0]         bit_idx_q;
  logic                  s0_q;
  logic                  s1_q;
  logic                  vote;
  logic                  vote_pt;
  logic                  end_bit;
  logic                  start_det;
  logic                  last_bit;
  logic                  frame_active;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_bit_q;
  logic                  par_err_q;
  logic                  stop1_vote_q;
  logic                  data_zero;
  logic                  exp_par;
  logic                  wr_strobe;
  logic                  new_stop_err;
  logic                  new_break;
  logic                  wr_req_q;
  logic [EW-1:0]         entry_q;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  overrun_q;
  logic                  fifo_valid;
  logic                  fifo_full;
  logic                  do_pop;
  logic                  do_push;
  logic [EW-1:0]         head;

  assign rx_s = sync_q[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], RX_IN};
      rx_prev <= rx_s;
    end
  end

  // The start-detection cycle counts as count 0 of the start bit, so every
  // bit (including the start bit) spans exactly P cycles of the synced line.
  assign half         = {1'b0, p_lat[5:1]};
  assign half_m1      = half - 6'd1;
  assign half_p1      = half + 6'd1;
  assign last_cnt     = p_lat - 6'd1;
  assign vote_pt      = (cnt_q == half_p1);
  assign end_bit      = (cnt_q == last_cnt);
  assign vote         = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign start_det    = (state_q == ST_IDLE) && rx_prev && !rx_s;
  assign last_bit     = (bit_idx_q == LAST_BIT);
  assign frame_active = (state_q != ST_IDLE) && (state_q != ST_WAIT_IDLE);
  assign data_zero    = (data_q == '0);
  assign exp_par      = (^data_q) ^ par_typ_lat;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_strobe    = 1'b0;
    new_stop_err = 1'b0;
    new_break    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_det) state_d = ST_START;
      end
      ST_START: begin
        if (vote_pt && vote) state_d = ST_IDLE;
        else if (end_bit)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (end_bit && last_bit) state_d = par_en_lat ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (end_bit) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (!stop2_lat) begin
          if (vote_pt) begin
            wr_strobe    = 1'b1;
            new_stop_err = !vote;
            new_break    = data_zero && !par_bit_q && !vote;
            state_d      = vote ? ST_IDLE : ST_WAIT_IDLE;
          end
        end else if (end_bit) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (vote_pt) begin
          wr_strobe    = 1'b1;
          new_stop_err = !stop1_vote_q || !vote;
          new_break    = data_zero && !par_bit_q && !stop1_vote_q;
          state_d      = vote ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_lat        <= '0;
      par_en_lat   <= 1'b0;
      par_typ_lat  <= 1'b0;
      stop2_lat    <= 1'b0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      data_q       <= '0;
      par_bit_q    <= 1'b0;
      par_err_q    <= 1'b0;
      stop1_vote_q <= 1'b1;
      wr_req_q     <= 1'b0;
      entry_q      <= '0;
    end else begin
      wr_req_q <= wr_strobe;
      if (wr_strobe) entry_q <= {new_break, new_stop_err, par_err_q, data_q};
      if (start_det) begin
        p_lat        <= Prescale;
        par_en_lat   <= PAR_EN;
        par_typ_lat  <= PAR_TYP;
        stop2_lat    <= STOP2;
        cnt_q        <= 6'd1;
        bit_idx_q    <= '0;
        data_q       <= '0;
        par_bit_q    <= 1'b0;
        par_err_q    <= 1'b0;
        stop1_vote_q <= 1'b1;
      end else if (frame_active) begin
        cnt_q <= end_bit ? 6'd0 : cnt_q + 6'd1;
        if (cnt_q == half_m1) s0_q <= rx_s;
        if (cnt_q == half)    s1_q <= rx_s;
        if (state_q == ST_DATA && vote_pt) begin
          if (MSB_FIRST) data_q <= {data_q[DATA_WIDTH-2:0], vote};
          else           data_q <= {vote, data_q[DATA_WIDTH-1:1]};
        end
        if (state_q == ST_DATA && end_bit) bit_idx_q <= last_bit ? '0 : bit_idx_q + 1'b1;
        if (state_q == ST_PARITY && vote_pt) begin
          par_bit_q <= vote;
          par_err_q <= (vote != exp_par);
        end
        if (state_q == ST_STOP1 && vote_pt) stop1_vote_q <= vote;
      end
    end
  end

  // A write into a full FIFO succeeds only when the head is popped in the same cycle.
  assign fifo_valid = (count_q != '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  assign do_pop     = fifo_valid && Data_Ready;
  assign do_push    = wr_req_q && (!fifo_full || do_pop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= wr_req_q && fifo_full && !do_pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_q] <= entry_q;
  end

  assign head         = fifo_valid ? mem[rd_ptr_q] : '0;
  assign P_DATA       = head[DATA_WIDTH-1:0];
  assign Parity_Error = head[DATA_WIDTH];
  assign Stop_Error   = head[DATA_WIDTH+1];
  assign Break        = head[DATA_WIDTH+2];
  assign Data_Valid   = fifo_valid;
  assign Overrun      = overrun_q;
  assign Fifo_Count   = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized and directed bench for uart_rx_fifo; expected entries come from a
// frame-level model (per-frame flag rules plus a bounded queue for the FIFO).
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          RX_IN;
  logic [5:0]    Prescale;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          STOP2;
  logic          Data_Ready;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          Parity_Error;
  logic          Stop_Error;
  logic          Break;
  logic          Overrun;
  logic [2:0]    Fifo_Count;

  uart_rx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STOP2(STOP2), .Data_Ready(Data_Ready), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .Parity_Error(Parity_Error), .Stop_Error(Stop_Error),
    .Break(Break), .Overrun(Overrun), .Fifo_Count(Fifo_Count)
  );

  always #5 CLK = ~CLK;

  int          checkCount  = 0;
  int          failCount   = 0;
  int          overrunSeen = 0;
  int          expOverrun  = 0;
  logic [10:0] expQ[$];
  logic [10:0] popped;
  int          cfgP;
  bit          cfgParEn;
  bit          cfgParTyp;
  bit          cfgStop2;

  always @(negedge CLK) begin
    if (RST && Overrun) overrunSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveConfig();
    Prescale = 6'(cfgP);
    PAR_EN   = cfgParEn;
    PAR_TYP  = cfgParTyp;
    STOP2    = cfgStop2;
  endtask

  function automatic logic [10:0] modelEntry(input logic [7:0] d, input bit parBit, input bit sA, input bit sB);
    bit perr;
    bit serr;
    bit brk;
    perr = cfgParEn && (parBit != ((^d) ^ cfgParTyp));
    serr = !sA || (cfgStop2 && !sB);
    brk  = (d == 8'h00) && !(cfgParEn && parBit) && !sA;
    return {brk, serr, perr, d};
  endfunction

  task automatic modelWrite(input logic [10:0] e);
    if (expQ.size() == DEPTH) expOverrun++;
    else expQ.push_back(e);
  endtask

  task automatic sendBit(input bit b, input bit popAtWrite);
    RX_IN = b;
    for (int c = 1; c <= cfgP; c++) begin
      @(negedge CLK);
      if (popAtWrite && c == 4 + cfgP / 2) begin
        checkOutput("popAtWriteHead", {Break, Stop_Error, Parity_Error, P_DATA}, expQ[0]);
        Data_Ready = 1'b1;
        popped = expQ.pop_front();
      end else if (popAtWrite && c == 5 + cfgP / 2) begin
        Data_Ready = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit parBit, input bit sA, input bit sB,
                               input bit scramble, input bit popAtWrite);
    driveConfig();
    sendBit(1'b0, 1'b0);
    if (scramble) begin
      Prescale = 6'($urandom_range(4, 63));
      PAR_EN   = ~cfgParEn;
      PAR_TYP  = ~cfgParTyp;
      STOP2    = ~cfgStop2;
    end
    for (int i = 0; i < DW; i++) sendBit(d[i], 1'b0);
    if (cfgParEn) sendBit(parBit, 1'b0);
    sendBit(sA, popAtWrite && !cfgStop2);
    if (cfgStop2) sendBit(sB, popAtWrite);
    driveConfig();
    modelWrite(modelEntry(d, parBit, sA, sB));
  endtask

  task automatic idleBits(input int n);
    RX_IN = 1'b1;
    repeat (n * cfgP) @(negedge CLK);
  endtask

  task automatic drainAndCheck();
    logic [10:0] e;
    bit          ok;
    checkOutput("fifoCount", Fifo_Count, expQ.size());
    checkOutput("overrunCount", overrunSeen, expOverrun);
    while (expQ.size() > 0) begin
      e  = expQ.pop_front();
      ok = 1'b0;
      for (int w = 0; w < 200 && !ok; w++) begin
        if (Data_Valid) ok = 1'b1;
        else @(negedge CLK);
      end
      checkOutput("validBeforePop", ok, 1'b1);
      if (ok) begin
        checkOutput("headEntry", {Break, Stop_Error, Parity_Error, P_DATA}, e);
        Data_Ready = 1'b1;
        @(negedge CLK);
        Data_Ready = 1'b0;
      end
    end
    @(negedge CLK);
    checkOutput("drainedCount", Fifo_Count, 0);
    checkOutput("drainedValid", Data_Valid, 0);
    checkOutput("emptyHead", {Break, Stop_Error, Parity_Error, P_DATA}, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    bit         pb;
    bit         sA;
    bit         sB;
    bit         finalStop;
    int         nFrames;

    RST = 1'b1;
    RX_IN = 1'b1;
    Data_Ready = 1'b0;
    cfgP = 8; cfgParEn = 1'b0; cfgParTyp = 1'b0; cfgStop2 = 1'b0;
    driveConfig();
    #2 RST = 1'b0;
    #10;
    checkOutput("resetOutputs",
                {P_DATA, Data_Valid, Parity_Error, Stop_Error, Break, Overrun, Fifo_Count}, 0);
    @(negedge CLK);
    RST = 1'b1;
    idleBits(2);

    $display("[TB] glitch on start bit");
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    idleBits(3);
    checkOutput("glitchValid", Data_Valid, 0);
    checkOutput("glitchCount", Fifo_Count, 0);

    Data_Ready = 1'b1;
    repeat (5) @(negedge CLK);
    Data_Ready = 1'b0;
    checkOutput("readyWhileEmpty", Fifo_Count, 0);

    $display("[TB] normal frame and parity");
    cfgParEn = 1'b1; cfgParTyp = 1'b0;
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    checkOutput("normalFrame", {Break, Stop_Error, Parity_Error, P_DATA}, 11'h0A5);
    drainAndCheck();
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    checkOutput("parityErrFrame", {Break, Stop_Error, Parity_Error, P_DATA}, 11'h1A5);
    drainAndCheck();
    cfgParTyp = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    drainAndCheck();

    $display("[TB] stop error and break");
    cfgParEn = 1'b0; cfgParTyp = 1'b0;
    applyStimulus(8'hF3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    checkOutput("stopErrFrame", {Break, Stop_Error, Parity_Error, P_DATA}, 11'h2F3);
    drainAndCheck();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    RX_IN = 1'b0;
    repeat (30 * cfgP) @(negedge CLK);
    idleBits(2);
    checkOutput("breakOneEntry", Fifo_Count, 1);
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    drainAndCheck();

    $display("[TB] back-to-back frames");
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    drainAndCheck();
    cfgStop2 = 1'b1; cfgP = 16;
    applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    drainAndCheck();

    $display("[TB] overrun");
    cfgStop2 = 1'b0; cfgP = 8;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(8'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idleBits(2);
    end
    checkOutput("overrunFull", Fifo_Count, 4);
    drainAndCheck();
    cfgP = 16;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(8'(8'h10 + i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idleBits(2);
    end
    applyStimulus(8'h15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idleBits(2);
    checkOutput("popAtWriteCount", Fifo_Count, 4);
    drainAndCheck();

    $display("[TB] randomized frames");
    for (int iter = 0; iter < 16; iter++) begin
      cfgP      = $urandom_range(4, 20);
      cfgParEn  = 1'($urandom_range(0, 1));
      cfgParTyp = 1'($urandom_range(0, 1));
      cfgStop2  = 1'($urandom_range(0, 1));
      driveConfig();
      idleBits(1);
      nFrames = $urandom_range(1, 5);
      for (int f = 0; f < nFrames; f++) begin
        d  = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) d = 8'h00;
        pb = (^d) ^ cfgParTyp;
        if ($urandom_range(0, 4) == 0) pb = ~pb;
        sA = ($urandom_range(0, 6) != 0);
        sB = ($urandom_range(0, 6) != 0);
        applyStimulus(d, pb, sA, sB, 1'($urandom_range(0, 1)), 1'b0);
        finalStop = cfgStop2 ? sB : sA;
        if (!finalStop || f == nFrames - 1 || $urandom_range(0, 1) == 0) idleBits(2);
      end
      drainAndCheck();
    end

    $display("[TB] reset mid-frame");
    cfgP = 8; cfgParEn = 1'b0; cfgStop2 = 1'b0;
    applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    checkOutput("preResetCount", Fifo_Count, 1);
    RX_IN = 1'b0;
    repeat (3 * cfgP) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("midFrameReset",
                {P_DATA, Data_Valid, Parity_Error, Stop_Error, Break, Overrun, Fifo_Count}, 0);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    expQ.delete();
    idleBits(2);
    applyStimulus(8'h96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idleBits(2);
    drainAndCheck();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
